// File: rtl/i2s_rx_bram_writer_pkg.sv
// Shared audio definitions for the I2S record path: sample width, clip length,
// the packed stereo BRAM word and the I2S channel encoding.
package i2s_rx_bram_writer_pkg;

  localparam int unsigned SAMPLE_BITS = 16;
  localparam int unsigned CLIP_LEN    = 256;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } i2s_ch_e;

  typedef struct packed {
    logic [15:0] right;
    logic [15:0] left;
  } stereo_word_t;

endpackage

// File: rtl/i2s_rx_bram_writer_if.sv
// Shared BRAM write port driven by the record path; the slave side is the BRAM.
interface i2s_rx_bram_writer_if;

  logic [31:0] BRAM_addr;
  logic        BRAM_clk;
  logic [31:0] BRAM_din;
  logic        BRAM_en;
  logic        BRAM_rst;
  logic [3:0]  BRAM_we;

  modport master (
    output BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we
  );

  modport slave (
    input BRAM_addr, BRAM_clk, BRAM_din, BRAM_en, BRAM_rst, BRAM_we
  );

endinterface

// File: rtl/i2s_rx_bram_writer_deser.sv
// I2S record deserialiser: oversamples bclk/lrc/data on clk, captures MSB-first
// samples per slot and flags complete left+right frames.
module i2s_rx_deser #(
  parameter int unsigned SAMPLE_BITS = i2s_rx_bram_writer_pkg::SAMPLE_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bclk_i,
  input  logic        lrc_i,
  input  logic        dat_i,
  output logic        frame_rdy,
  output logic        frame_start,
  output logic [15:0] left,
  output logic [15:0] right
);
  import i2s_rx_bram_writer_pkg::*;

  localparam int unsigned CW  = $clog2(SAMPLE_BITS + 1);
  localparam int unsigned PAD = 16 - SAMPLE_BITS;

  logic bclk_m_q, bclk_s_q, bclk_p_q;
  logic lrc_m_q, lrc_s_q;
  logic dat_m_q, dat_s_q;

  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  i2s_ch_e                slot_ch_q, slot_ch_d;
  logic                   valid_q, valid_d;
  logic                   lrc_prev_q, lrc_prev_d;
  logic                   left_done_q, left_done_d;
  logic [15:0]            left_q, left_d, right_q, right_d;
  logic                   frame_rdy_q, frame_rdy_d;
  logic                   frame_start_q, frame_start_d;
  logic                   bit_edge;
  logic [15:0]            sample;

  assign bit_edge    = bclk_s_q & ~bclk_p_q;
  assign frame_rdy   = frame_rdy_q;
  assign frame_start = frame_start_q;
  assign left        = left_q;
  assign right       = right_q;

  // Data shifts before the slot-boundary update so a 16-bit slot's LSB lands in the old slot.
  always_comb begin
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    slot_ch_d     = slot_ch_q;
    valid_d       = valid_q;
    lrc_prev_d    = lrc_prev_q;
    left_done_d   = left_done_q;
    left_d        = left_q;
    right_d       = right_q;
    frame_rdy_d   = 1'b0;
    frame_start_d = 1'b0;
    sample        = 16'h0;
    if (bit_edge) begin
      if (valid_q && (cnt_q < CW'(SAMPLE_BITS))) begin
        shift_d = (shift_q << 1) | SAMPLE_BITS'(dat_s_q);
        cnt_d   = cnt_q + CW'(1);
        if (cnt_d == CW'(SAMPLE_BITS)) begin
          sample = 16'(shift_d) << PAD;
          if (slot_ch_q == LEFT) begin
            left_d      = sample;
            left_done_d = 1'b1;
          end else begin
            right_d     = sample;
            frame_rdy_d = left_done_q;
            left_done_d = 1'b0;
          end
        end
      end
      if (lrc_s_q != lrc_prev_q) begin
        cnt_d      = '0;
        slot_ch_d  = i2s_ch_e'(lrc_s_q);
        valid_d    = 1'b1;
        lrc_prev_d = lrc_s_q;
        if (lrc_prev_q && !lrc_s_q) begin
          frame_start_d = 1'b1;
          left_done_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bclk_m_q      <= 1'b0;
      bclk_s_q      <= 1'b0;
      bclk_p_q      <= 1'b0;
      lrc_m_q       <= 1'b0;
      lrc_s_q       <= 1'b0;
      dat_m_q       <= 1'b0;
      dat_s_q       <= 1'b0;
      shift_q       <= '0;
      cnt_q         <= '0;
      slot_ch_q     <= LEFT;
      valid_q       <= 1'b0;
      lrc_prev_q    <= 1'b0;
      left_done_q   <= 1'b0;
      left_q        <= '0;
      right_q       <= '0;
      frame_rdy_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      bclk_m_q      <= bclk_i;
      bclk_s_q      <= bclk_m_q;
      bclk_p_q      <= bclk_s_q;
      lrc_m_q       <= lrc_i;
      lrc_s_q       <= lrc_m_q;
      dat_m_q       <= dat_i;
      dat_s_q       <= dat_m_q;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      slot_ch_q     <= slot_ch_d;
      valid_q       <= valid_d;
      lrc_prev_q    <= lrc_prev_d;
      left_done_q   <= left_done_d;
      left_q        <= left_d;
      right_q       <= right_d;
      frame_rdy_q   <= frame_rdy_d;
      frame_start_q <= frame_start_d;
    end
  end

endmodule

// File: rtl/i2s_rx_bram_writer.sv
// I2S record capture into a BRAM ring/one-shot buffer: one {right,left} word per
// frame, written through the shared BRAM port.
module i2s_rx_bram_writer #(
  parameter int unsigned SAMPLE_BITS = i2s_rx_bram_writer_pkg::SAMPLE_BITS,
  parameter int unsigned NUM_WORDS   = i2s_rx_bram_writer_pkg::CLIP_LEN,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         audio_I2S_bclk,
  input  logic                         audio_I2S_reclrc,
  input  logic                         audio_I2S_recdat,
  input  logic                         enable,
  input  logic                         continuous,
  i2s_rx_bram_writer_if.master         bram,
  output logic [$clog2(NUM_WORDS)-1:0] wr_index,
  output logic                         done,
  output logic                         overrun
);
  import i2s_rx_bram_writer_pkg::*;

  localparam int unsigned IW = $clog2(NUM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_CAPTURE, S_WRITE, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [IW-1:0] wr_index_q, wr_index_d;
  logic         enable_prev_q;
  logic         overrun_q, overrun_d;
  logic         done_q, done_d;
  logic         bram_en_q, bram_en_d;
  logic [31:0]  bram_addr_q, bram_addr_d;
  stereo_word_t bram_din_q, bram_din_d;
  logic         enable_rise;
  logic         frame_rdy, frame_start;
  logic [15:0]  left_s, right_s;

  i2s_rx_deser #(.SAMPLE_BITS(SAMPLE_BITS)) u_deser (
    .clk         (clk),
    .rst         (rst),
    .bclk_i      (audio_I2S_bclk),
    .lrc_i       (audio_I2S_reclrc),
    .dat_i       (audio_I2S_recdat),
    .frame_rdy   (frame_rdy),
    .frame_start (frame_start),
    .left        (left_s),
    .right       (right_s)
  );

  assign enable_rise    = enable & ~enable_prev_q;
  assign bram.BRAM_clk  = clk;
  assign bram.BRAM_rst  = 1'b0;
  assign bram.BRAM_en   = bram_en_q;
  assign bram.BRAM_we   = {4{bram_en_q}};
  assign bram.BRAM_addr = bram_addr_q;
  assign bram.BRAM_din  = bram_din_q;
  assign wr_index       = wr_index_q;
  assign done           = done_q;
  assign overrun        = overrun_q;

  // Write-port outputs are registered off the transition into WRITE.
  always_comb begin
    state_d     = state_q;
    wr_index_d  = wr_index_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    bram_en_d   = 1'b0;
    bram_addr_d = '0;
    bram_din_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (enable_rise) begin
          wr_index_d = '0;
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (frame_start) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (frame_rdy) begin
          state_d          = S_WRITE;
          bram_en_d        = 1'b1;
          bram_addr_d      = BASE_ADDR + (32'(wr_index_q) << 2);
          bram_din_d.right = right_s;
          bram_din_d.left  = left_s;
        end
      end
      S_WRITE: begin
        wr_index_d = wr_index_q + IW'(1);
        if (frame_rdy) overrun_d = 1'b1;
        if (wr_index_q == IW'(NUM_WORDS - 1)) begin
          if (continuous) begin
            done_d  = 1'b1;
            state_d = S_CAPTURE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE) done_d = 1'b1;
    // Dropping enable abandons any partial frame; a write already on the port still lands.
    if (!enable) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      bram_en_d   = 1'b0;
      bram_addr_d = '0;
      bram_din_d  = '0;
    end
    if (enable_rise) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wr_index_q    <= '0;
      enable_prev_q <= 1'b0;
      overrun_q     <= 1'b0;
      done_q        <= 1'b0;
      bram_en_q     <= 1'b0;
      bram_addr_q   <= '0;
      bram_din_q    <= '0;
    end else begin
      state_q       <= state_d;
      wr_index_q    <= wr_index_d;
      enable_prev_q <= enable;
      overrun_q     <= overrun_d;
      done_q        <= done_d;
      bram_en_q     <= bram_en_d;
      bram_addr_q   <= bram_addr_d;
      bram_din_q    <= bram_din_d;
    end
  end

endmodule

// File: tb/tb_i2s_rx_bram_writer.sv
// Scoreboard bench for i2s_rx_bram_writer: directed I2S frames, expected BRAM writes
// queued by the stimulus and checked by an independent write-port monitor.
module tb_i2s_rx_bram_writer;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       bclk, lrc, dat;
  logic       enable, continuous;
  logic [1:0] wr_index;
  logic       done, overrun;
  logic       carry;

  int   errors = 0;
  int   checks = 0;
  int   done_cycles = 0;
  logic chk_done_next = 1'b0;
  exp_t exp_q[$];

  i2s_rx_bram_writer_if bram_if ();

  i2s_rx_bram_writer #(.SAMPLE_BITS(16), .NUM_WORDS(4), .BASE_ADDR(32'h0)) dut (
    .clk              (clk),
    .rst              (rst),
    .audio_I2S_bclk   (bclk),
    .audio_I2S_reclrc (lrc),
    .audio_I2S_recdat (dat),
    .enable           (enable),
    .continuous       (continuous),
    .bram             (bram_if),
    .wr_index         (wr_index),
    .done             (done),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic slot_bit(input logic [15:0] w, input int j);
    logic [15:0] t;
    t = w;
    return (j < 16) ? t[15 - j] : 1'b0;
  endfunction

  // One I2S slot of 'width' bclk periods, data delayed one bit behind lrc.
  task automatic drive_slot(input logic ch, input logic [15:0] w, input int width,
                            input int ev_bit = -1, input logic ev_en = 1'b0);
    for (int i = 0; i < width; i++) begin
      bclk = 1'b0;
      lrc  = ch;
      dat  = (i == 0) ? carry : slot_bit(w, i - 1);
      if (i == ev_bit) enable = ev_en;
      #40;
      bclk = 1'b1;
      #40;
    end
    carry = slot_bit(w, width - 1);
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r, input int width);
    drive_slot(1'b0, l, width);
    drive_slot(1'b1, r, width);
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    e.addr = addr;
    e.din  = {r, l};
    exp_q.push_back(e);
  endtask

  task automatic disarm();
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_cleared", 32'(done), 32'h0);
  endtask

  // Write-port monitor: every BRAM_en cycle must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (chk_done_next) chk("done_pulse_after_wrap", 32'(done), 32'h1);
      chk_done_next = 1'b0;
      if (bram_if.BRAM_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr=%h din=%h, no write expected",
                   bram_if.BRAM_addr, bram_if.BRAM_din);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", bram_if.BRAM_addr, e.addr);
          chk("write_din", bram_if.BRAM_din, e.din);
          chk("write_we", 32'(bram_if.BRAM_we), 32'hF);
        end
        if (continuous && bram_if.BRAM_addr == 32'hC) chk_done_next = 1'b1;
      end
      if (done && continuous) done_cycles++;
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; continuous = 1'b0;
    bclk = 1'b0; lrc = 1'b0; dat = 1'b0; carry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_en", 32'(bram_if.BRAM_en), 32'h0);
    chk("reset_we", 32'(bram_if.BRAM_we), 32'h0);
    chk("reset_addr", bram_if.BRAM_addr, 32'h0);
    chk("reset_din", bram_if.BRAM_din, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_overrun", 32'(overrun), 32'h0);
    chk("reset_wr_index", 32'(wr_index), 32'h0);
    chk("bram_rst_tied", 32'(bram_if.BRAM_rst), 32'h0);
    #2 rst = 1'b0;

    // 1: 32-bit slots, one-shot of four words, fifth frame must not be written
    enable = 1'b1;
    drive_slot(1'b1, 16'h0, 32);
    for (int k = 0; k < 4; k++) expect_wr(32'(k * 4), 16'hA55A, 16'h1234);
    for (int k = 0; k < 5; k++) frame(16'hA55A, 16'h1234, 32);
    #1;
    chk("t1_pending", 32'(exp_q.size()), 32'h0);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_overrun", 32'(overrun), 32'h0);
    disarm();

    // 2: 16-bit slots, LSB arrives on the boundary edge
    enable = 1'b1;
    drive_slot(1'b1, 16'h0, 16);
    for (int k = 0; k < 4; k++) expect_wr(32'(k * 4), 16'h8001, 16'h7FFE);
    for (int k = 0; k < 4; k++) frame(16'h8001, 16'h7FFE, 16);
    drive_slot(1'b0, 16'h0, 16);
    #1;
    chk("t2_pending", 32'(exp_q.size()), 32'h0);
    chk("t2_done", 32'(done), 32'h1);
    disarm();

    // 3: arming mid right slot drops the partial frame
    drive_slot(1'b0, 16'h1111, 32);
    drive_slot(1'b1, 16'h2222, 32, 8, 1'b1);
    expect_wr(32'h0, 16'h3C3C, 16'h4D4D);
    expect_wr(32'h4, 16'h5E5E, 16'h6F6F);
    frame(16'h3C3C, 16'h4D4D, 32);
    frame(16'h5E5E, 16'h6F6F, 32);
    #1;
    chk("t3_pending", 32'(exp_q.size()), 32'h0);
    chk("t3_wr_index", 32'(wr_index), 32'h2);
    disarm();

    // 4: continuous wrap over six frames
    continuous = 1'b1;
    done_cycles = 0;
    enable = 1'b1;
    drive_slot(1'b1, 16'h0, 32);
    for (int k = 0; k < 6; k++) begin
      expect_wr(32'((k % 4) * 4), 16'h1000 + 16'(k), 16'h2000 + 16'(k));
      frame(16'h1000 + 16'(k), 16'h2000 + 16'(k), 32);
    end
    #1;
    chk("t4_pending", 32'(exp_q.size()), 32'h0);
    chk("t4_done_cycles", 32'(done_cycles), 32'h1);
    chk("t4_wr_index", 32'(wr_index), 32'h2);
    chk("t4_overrun", 32'(overrun), 32'h0);
    disarm();
    continuous = 1'b0;

    // 5: disarm mid left slot of frame 3, then re-arm from word 0
    enable = 1'b1;
    drive_slot(1'b1, 16'h0, 32);
    expect_wr(32'h0, 16'h0101, 16'h0202);
    expect_wr(32'h4, 16'h0303, 16'h0404);
    frame(16'h0101, 16'h0202, 32);
    frame(16'h0303, 16'h0404, 32);
    drive_slot(1'b0, 16'h0505, 32, 5, 1'b0);
    drive_slot(1'b1, 16'h0606, 32);
    frame(16'h0707, 16'h0808, 32);
    #1;
    chk("t5_pending", 32'(exp_q.size()), 32'h0);
    chk("t5_done", 32'(done), 32'h0);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_rearm_index", 32'(wr_index), 32'h0);
    drive_slot(1'b1, 16'h0, 32);
    expect_wr(32'h0, 16'h0909, 16'h0A0A);
    frame(16'h0909, 16'h0A0A, 32);
    #1;
    chk("t5_rearm_pending", 32'(exp_q.size()), 32'h0);
    disarm();

    // 6: reset mid frame, then no capture until a fresh enable edge
    enable = 1'b1;
    drive_slot(1'b1, 16'h0, 32);
    expect_wr(32'h0, 16'h1111, 16'h2222);
    frame(16'h1111, 16'h2222, 32);
    fork
      drive_slot(1'b0, 16'h3333, 32);
      begin
        #1203 rst = 1'b1;
        #1;
        chk("t6_rst_en", 32'(bram_if.BRAM_en), 32'h0);
        chk("t6_rst_addr", bram_if.BRAM_addr, 32'h0);
        chk("t6_rst_wr_index", 32'(wr_index), 32'h0);
        chk("t6_rst_done", 32'(done), 32'h0);
        enable = 1'b0;
      end
    join
    #3 rst = 1'b0;
    drive_slot(1'b1, 16'h4444, 32);
    frame(16'h5555, 16'h6666, 32);
    frame(16'h5555, 16'h6666, 32);
    enable = 1'b1;
    drive_slot(1'b1, 16'h0, 32);
    expect_wr(32'h0, 16'h7777, 16'h8888);
    frame(16'h7777, 16'h8888, 32);
    #1;
    chk("t6_pending", 32'(exp_q.size()), 32'h0);
    chk("t6_overrun", 32'(overrun), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
